// File: rtl/vtg_pkg.sv
// Shared XGA 1024x768@60 timing constants for the video timing generator.
// Frame-tick pulse is built only when VTG_FRAME_TICK_EN is defined.
package vtg_pkg;

  localparam int CNT_W = 11;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP
                              + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP
                              + XGA_V_SYNC + XGA_V_BP;

  localparam logic [9:0] BLANK_COORD = 10'h3FF;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrap counter plus active-region and sync-window
// comparators. Instantiated once for horizontal, once for vertical.
module timing_axis_counter
  import vtg_pkg::*;
#(
  parameter int ACTIVE = XGA_H_ACTIVE,
  parameter int FP     = XGA_H_FP,
  parameter int SYNC   = XGA_H_SYNC,
  parameter int BP     = XGA_H_BP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             sync_win
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_C   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);

  // advance when enabled, wrapping to 0 after the last count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST_C) count <= '0;
      else                 count <= count + CNT_W'(1);
    end
  end

  assign active   = (count < ACT_C);
  assign sync_win = (count >= SYNC_LO) && (count < SYNC_HI);

endmodule

// File: rtl/video_timing_gen.sv
// XGA raster timing generator: registered, mutually aligned coordinates,
// video_on and syncs. Optional macro VTG_FRAME_TICK_EN adds frame_tick.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic [9:0] pixel_row,
  output logic [9:0] pixel_column,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             h_active;
  logic             v_active;
  logic             h_sync_win;
  logic             v_sync_win;
  logic             h_last;
  logic             visible;
  logic             unused_hi;

  timing_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clock    (clock),
    .reset    (reset),
    .en       (1'b1),
    .count    (h_count),
    .active   (h_active),
    .sync_win (h_sync_win)
  );

  assign h_last = (h_count == H_LAST);

  timing_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clock    (clock),
    .reset    (reset),
    .en       (h_last),
    .count    (v_count),
    .active   (v_active),
    .sync_win (v_sync_win)
  );

  assign visible   = h_active & v_active;
  assign unused_hi = ^{h_count[CNT_W-1:10], v_count[CNT_W-1:10]};

  // register all raster outputs from the same count pair
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      video_on     <= 1'b0;
      pixel_row    <= BLANK_COORD;
      pixel_column <= BLANK_COORD;
      horiz_sync   <= ~SYNC_POL;
      vert_sync    <= ~SYNC_POL;
    end else begin
      video_on     <= visible;
      pixel_row    <= visible ? v_count[9:0] : BLANK_COORD;
      pixel_column <= visible ? h_count[9:0] : BLANK_COORD;
      horiz_sync   <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vert_sync    <= v_sync_win ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VTG_FRAME_TICK_EN
  localparam logic [CNT_W-1:0] V_BLANK0 = CNT_W'(V_ACTIVE);

  // one pulse at the first blanking line, column 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= (v_count == V_BLANK0) && (h_count == '0);
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Display timing generator that drives the VGA/XGA pixel coordinate stream consumed by the icon, world-map and colorizer logic. It produces `pixel_row`, `pixel_column`, `video_on`, and the horizontal and vertical sync pulses for a 1024x768 @ 60 Hz raster (65 MHz pixel clock). All outputs are registered and mutually aligned, so downstream blocks compare `pixel_row`/`pixel_column` against `LocX*8`/`LocY*6` without any skew correction.

## Interface
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, horizontal sync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `SYNC_POL`, 0, sync active level; 0 = active-low, 1 = active-high
- `clock`, in, 1, pixel clock (65 MHz); only clock in the block
- `reset`, in, 1, asynchronous, active-high
- `horiz_sync`, out, 1, horizontal sync at `SYNC_POL` level
- `vert_sync`, out, 1, vertical sync at `SYNC_POL` level
- `video_on`, out, 1, high only in the visible region
- `pixel_row`, out, 10, current visible row 0..767; 10'h3FF during blanking
- `pixel_column`, out, 10, current visible column 0..1023; 10'h3FF during blanking
- `frame_tick`, out, 1, one-cycle pulse at start of vertical front porch (see Configuration)

## Operation
- Internal counters are 11 bits wide.
  - `h_count` runs 0..H_TOTAL-1, where H_TOTAL = sum of the H params (1344).
  - `v_count` runs 0..V_TOTAL-1, where V_TOTAL = 806.
- `h_count` increments every cycle and wraps to 0 after 1343.
- `v_count` increments only on cycles where `h_count`==1343. It wraps to 0 when `v_count`==805 and `h_count`==1343.
- `video_on` is set when `h_count`<H_ACTIVE and `v_count`<V_ACTIVE.
- `pixel_column` and `pixel_row` carry `h_count[9:0]` and `v_count[9:0]` when `video_on` is set; otherwise both are 10'h3FF. Downstream logic must qualify all coordinate use with `video_on`.
- `horiz_sync` is at its active level for H_ACTIVE+H_FP <= `h_count` < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
- `vert_sync` is at its active level for V_ACTIVE+V_FP <= `v_count` < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776. It spans whole lines, so its edges coincide with the `h_count` 1343→0 wrap.
- Reset values of outputs:
  - `video_on`=0, `frame_tick`=0
  - `pixel_row`=`pixel_column`=10'h3FF
  - syncs at inactive level (1 when `SYNC_POL`=0)
  - counters=0

## Timing
- All outputs are registered from the counter values with a fixed 1-cycle latency, and every output is aligned to the same count.
- First rising edge after `reset` falls: outputs show count (0,0), i.e. `video_on`=1, row 0, column 0.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronously). After release, the raster restarts at (0,0) with no partial line.
- Line period is 1344 cycles and frame period is 1344×806 = 1,083,264 cycles. Every frame must be exactly this length; there is no drift.

## Configuration
- `VTG_FRAME_TICK_EN` defined: `frame_tick` pulses high for exactly 1 cycle, aligned with the first output cycle where row count = 768 and column count = 0. That is once per frame, at the start of vertical blanking; it is used to latch LocX/LocY/BotInfo without tearing.
- `VTG_FRAME_TICK_EN` undefined: the pulse logic is absent and `frame_tick` is tied to 0. The port always exists.

## Structure
- Shared package `vtg_pkg`:
  - XGA timing localparams (H/V active, porch and sync values, H_TOTAL, V_TOTAL)
  - 11-bit count width constant
  - the blanking coordinate value 10'h3FF
- One natural sub-module, `timing_axis_counter`, instantiated once per axis. It contains:
  - a wrap counter with a count-enable input
  - an active-region comparator
  - a sync-window comparator
- The top level contains the two instances, the H→V enable chaining, the output registers and the optional frame-tick logic.

## Test plan
- Reset release, then run 1 cycle → `video_on`=1, `pixel_row`=0, `pixel_column`=0, `horiz_sync`=`vert_sync`=1. During reset: 10'h3FF, `video_on`=0.
- Run one line → `video_on` falls on output column 1024, giving 1024 visible cycles. `horiz_sync` is low for exactly 136 cycles, starting 24 cycles after `video_on` falls. Line period = 1344.
- Run a full frame → `vert_sync` low for 6×1344 cycles, starting at row 771 with column 0. Frame period = 1,083,264 cycles; the next frame starts at (0,0).
- Run continuously for 3 frames with `VTG_FRAME_TICK_EN` defined → exactly 3 `frame_tick` pulses, each 1 cycle wide and 1,083,264 cycles apart. Without the macro, `frame_tick` stays 0.
- Assert `reset` at row 400, column 500 → all outputs go to their reset values asynchronously. On release, the sequence restarts at (0,0).
- Track coordinates over a frame with a scoreboard → `pixel_column` is monotonic 0..1023 on every visible line and `pixel_row` is constant within a line. Output (767,1023) is followed by blanking, never row 768 with `video_on` set.
